// File: rtl/pll_rate_ctrl.sv
// PLL dynamic-reconfiguration sequencer for the audio rate families: programs the
// divider selects, pulses PLL reset, supervises lock with bounded retries, sticky FAIL.
module pll_rate_ctrl #(
   parameter int RESET_CYCLES  = 32,
   parameter int LOCK_TIMEOUT  = 27000,
   parameter int SETTLE_CYCLES = 256,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic [1:0] rate_sel,
   input  logic       req,
   input  logic       lock,
   output logic       pll_reset,
   output logic [5:0] idsel,
   output logic [5:0] fbdsel,
   output logic [5:0] odsel,
   output logic       busy,
   output logic       clk_ok,
   output logic       audio_rst,
   output logic       err,
   output logic [1:0] cur_rate
);

   localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CNT = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int RTY_W   = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      APPLY     = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [RTY_W-1:0] retry_r;
   logic [RTY_W-1:0] retry_s;
   logic [RTY_W-1:0] retry_inc_s;
   logic             retry_last_s;
   logic [1:0]       target_r;
   logic [1:0]       target_s;
   logic             lock_meta_r;
   logic             lock_sync_r;
   logic             req_ok_s;
   logic             enter_apply_s;

   // Returns {idsel, fbdsel, odsel}; the PLL wants the I/FB divider selects inverted.
   function automatic logic [17:0] div_sel(input logic [1:0] rate);
      logic [5:0] idiv;
      logic [5:0] fbdiv;
      logic [5:0] odiv;
      case (rate)
         2'd0:    begin idiv = 6'd0; fbdiv = 6'd15; odiv = 6'h3E; end
         2'd1:    begin idiv = 6'd4; fbdiv = 6'd48; odiv = 6'h3C; end
         2'd2:    begin idiv = 6'd2; fbdiv = 6'd31; odiv = 6'h38; end
         default: begin idiv = 6'd0; fbdiv = 6'd15; odiv = 6'h3E; end
      endcase
      return {~idiv, ~fbdiv, odiv};
   endfunction

   assign cnt_inc_s    = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
   assign retry_inc_s  = (retry_r == {RTY_W{1'b1}}) ? retry_r : retry_r + RTY_W'(1);
   assign retry_last_s = (retry_inc_s == RTY_LIMIT);

   // Requests are honoured only from a settled state; a same-rate request in RUN is a no-op.
   assign req_ok_s = req && (rate_sel != 2'd3) &&
                     (((state_r == RUN) && (rate_sel != cur_rate)) || (state_r == FAIL));

   assign enter_apply_s = (state_s == APPLY) && (state_r != APPLY);

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clkin) begin
      if (reset) begin
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         lock_meta_r <= lock;
         lock_sync_r <= lock_meta_r;
      end
   end

   // Next-state, counter and retry logic.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      retry_s  = retry_r;
      target_s = target_r;
      if (req_ok_s) begin
         state_s  = APPLY;
         cnt_s    = {CNT_W{1'b0}};
         retry_s  = {RTY_W{1'b0}};
         target_s = rate_sel;
      end else begin
         case (state_r)
            APPLY: begin
               if (cnt_r == RST_LAST) begin
                  state_s = WAIT_LOCK;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_inc_s;
               end
            end
            WAIT_LOCK: begin
               if (lock_sync_r) begin
                  state_s = SETTLE;
                  cnt_s   = {CNT_W{1'b0}};
               end else if (cnt_r == TMO_LAST) begin
                  retry_s = retry_inc_s;
                  cnt_s   = {CNT_W{1'b0}};
                  state_s = retry_last_s ? FAIL : APPLY;
               end else begin
                  cnt_s = cnt_inc_s;
               end
            end
            SETTLE: begin
               if (!lock_sync_r) begin
                  retry_s = retry_inc_s;
                  cnt_s   = {CNT_W{1'b0}};
                  state_s = retry_last_s ? FAIL : APPLY;
               end else if (cnt_r == SETTLE_LAST) begin
                  state_s = RUN;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_inc_s;
               end
            end
            RUN: begin
               if (!lock_sync_r) begin
                  state_s = APPLY;
                  cnt_s   = {CNT_W{1'b0}};
                  retry_s = {RTY_W{1'b0}};
               end else begin
                  state_s = RUN;
               end
            end
            FAIL: begin
               state_s = FAIL;
            end
            default: begin
               state_s = APPLY;
               cnt_s   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state_r  <= APPLY;
         cnt_r    <= {CNT_W{1'b0}};
         retry_r  <= {RTY_W{1'b0}};
         target_r <= 2'd0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         retry_r  <= retry_s;
         target_r <= target_s;
      end
   end

   // Outputs registered from the next state so they line up with the state register.
   always_ff @(posedge clkin) begin
      if (reset) begin
         pll_reset               <= 1'b1;
         busy                    <= 1'b1;
         clk_ok                  <= 1'b0;
         audio_rst               <= 1'b1;
         err                     <= 1'b0;
         cur_rate                <= 2'd0;
         {idsel, fbdsel, odsel}  <= div_sel(2'd0);
      end else begin
         pll_reset <= (state_s == APPLY) || (state_s == FAIL);
         busy      <= (state_s == APPLY) || (state_s == WAIT_LOCK) || (state_s == SETTLE);
         clk_ok    <= (state_s == RUN);
         audio_rst <= (state_s != RUN);
         err       <= (state_s == FAIL);
         if (enter_apply_s) begin
            cur_rate               <= target_s;
            {idsel, fbdsel, odsel} <= div_sel(target_s);
         end else begin
            cur_rate               <= cur_rate;
            {idsel, fbdsel, odsel} <= {idsel, fbdsel, odsel};
         end
      end
   end

endmodule
